// File: rtl/multdiv_pw_pkg.sv
// Shared encodings and helpers for the PW multiply/divide stage.
// Instruction fields, opcodes and the stage state encoding.
package multdiv_pw_pkg;

  localparam logic [4:0] OP_ALU  = 5'd0;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_LW   = 5'd8;

  localparam logic [4:0] ALUOP_MUL = 5'd6;
  localparam logic [4:0] ALUOP_DIV = 5'd7;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  function automatic logic [4:0] opField(
    input logic [31:0] ir
  );
    return ir[31:27];
  endfunction

  function automatic logic [4:0] rdField(
    input logic [31:0] ir
  );
    return ir[26:22];
  endfunction

  function automatic logic [4:0] rsField(
    input logic [31:0] ir
  );
    return ir[21:17];
  endfunction

  function automatic logic [4:0] rtField(
    input logic [31:0] ir
  );
    return ir[16:12];
  endfunction

  function automatic logic [4:0] aluopField(
    input logic [31:0] ir
  );
    return ir[6:2];
  endfunction

  function automatic logic isMulDivIr(
    input logic [31:0] ir
  );
    return (opField(ir) == OP_ALU) &&
           ((aluopField(ir) == ALUOP_MUL) ||
            (aluopField(ir) == ALUOP_DIV));
  endfunction

endpackage

// File: rtl/multdiv_iter_core.sv
// Iterative datapath: radix-2 Booth multiply and restoring divide.
// done and the final result are combinational in the last step cycle.
module multdiv_iter_core
  import multdiv_pw_pkg::*;
#(
  parameter int ITER = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] result,
  output logic        exception
);

  localparam int CW = $clog2(ITER);

  logic            active;
  logic            isDiv;
  logic            neg;
  logic [32:0]     acc;
  logic [32:0]     m;
  logic [31:0]     q;
  logic            qm1;
  logic [CW-1:0]   cnt;

  logic [32:0]     sum;
  logic [32:0]     shifted;
  logic [33:0]     diff;
  logic [32:0]     accNext;
  logic [31:0]     qNext;
  logic            qm1Next;
  logic [63:0]     product;
  logic [31:0]     quot;

  function automatic logic [31:0] mag(
    input logic [31:0] v
  );
    return v[31] ? -v : v;
  endfunction

  always_comb begin
    sum     = acc;
    shifted = {acc[31:0], q[31]};
    diff    = {1'b0, shifted} - {1'b0, m};
    accNext = acc;
    qNext   = q;
    qm1Next = qm1;
    unique case ({q[0], qm1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
    if (isDiv) begin
      accNext = diff[33] ? shifted : diff[32:0];
      qNext   = {q[30:0], ~diff[33]};
      qm1Next = 1'b0;
    end else begin
      accNext = {sum[32], sum[32:1]};
      qNext   = {sum[0], q[31:1]};
      qm1Next = q[0];
    end
  end

  always_comb begin
    product = {accNext[31:0], qNext};
    quot    = neg ? -qNext : qNext;
  end

  assign done = active && (cnt == CW'(ITER - 1));

  // A positive quotient of 2^31 only arises from 0x80000000 / -1.
  assign result    = isDiv ? quot : product[31:0];
  assign exception = isDiv ? (qNext[31] & ~neg)
                           : ~((&product[63:31]) |
                               ~(|product[63:31]));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active <= 1'b0;
      isDiv  <= 1'b0;
      neg    <= 1'b0;
      acc    <= '0;
      m      <= '0;
      q      <= '0;
      qm1    <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      isDiv  <= op;
      neg    <= op & (a[31] ^ b[31]);
      acc    <= '0;
      m      <= op ? {1'b0, mag(b)} : {b[31], b};
      q      <= op ? mag(a) : a;
      qm1    <= 1'b0;
      cnt    <= '0;
    end else if (active) begin
      acc <= accNext;
      q   <= qNext;
      qm1 <= qm1Next;
      cnt <= cnt + CW'(1);
      if (done) begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multdiv_pw_stage.sv
// PW latch beside execute: accepts mul/div from DX, stalls the front
// end while computing, and strobes a single write-back when done.
module multdiv_pw_stage
  import multdiv_pw_pkg::*;
#(
  parameter int ITER = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] DXIR,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic        wbBusy,
  output logic [31:0] PWIR,
  output logic [31:0] result,
  output logic        exception,
  output logic        multOrDivReady,
  output logic        busy
);

  state_t      state;
  logic        start;
  logic        isDivOp;
  logic        divZero;
  logic        coreStart;
  logic        coreDone;
  logic [31:0] coreResult;
  logic        coreExc;

  // Gated by reset_n so a mul/div held in DX cannot stall during reset.
  assign start     = reset_n && (state == IDLE) && isMulDivIr(DXIR);
  assign isDivOp   = aluopField(DXIR) == ALUOP_DIV;
  assign divZero   = isDivOp && (operandB == '0);
  assign coreStart = start && !divZero;

  assign multOrDivReady = (state == DONE) && !wbBusy;
  assign busy = start ||
                (state == MUL) ||
                (state == DIV) ||
                ((state == DONE) && !multOrDivReady);

  multdiv_iter_core #(
    .ITER(ITER)
  ) core (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (coreStart),
    .op       (isDivOp),
    .a        (operandA),
    .b        (operandB),
    .done     (coreDone),
    .result   (coreResult),
    .exception(coreExc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      PWIR      <= '0;
      result    <= '0;
      exception <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            PWIR <= DXIR;
            if (divZero) begin
              state     <= DONE;
              result    <= '0;
              exception <= 1'b1;
            end else begin
              state <= isDivOp ? DIV : MUL;
            end
          end
        end
        MUL, DIV: begin
          if (coreDone) begin
            state     <= DONE;
            result    <= coreResult;
            exception <= coreExc;
          end
        end
        DONE: begin
          if (!wbBusy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_pw_stage.sv
// Directed vector bench for multdiv_pw_stage: timing, arithmetic,
// write-back deferral, back-to-back issue and mid-operation reset.
module tb_multdiv_pw_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] DXIR;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        wbBusy;
  logic [31:0] PWIR;
  logic [31:0] result;
  logic        exception;
  logic        multOrDivReady;
  logic        busy;

  int nCmp = 0;
  int nBad = 0;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
    int          lat;
    int          wb;
  } vec_t;

  vec_t vecs[16];

  multdiv_pw_stage #(
    .ITER(32)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .DXIR          (DXIR),
    .operandA      (operandA),
    .operandB      (operandB),
    .wbBusy        (wbBusy),
    .PWIR          (PWIR),
    .result        (result),
    .exception     (exception),
    .multOrDivReady(multOrDivReady),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mk(
    input logic [4:0] op,
    input logic [4:0] rd,
    input logic [4:0] aluop
  );
    return {op, rd, 5'd1, 5'd2, 5'd0, aluop, 2'b00};
  endfunction

  // addi opcode with the mul ALUop pattern: must not be taken
  localparam logic [31:0] NOP = 32'h2D42_2018;

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic runOp(input vec_t v, input string tag);
    int rdy;
    int first;
    int pulses;
    int busyErr;
    rdy = v.lat + v.wb;
    first = -1;
    pulses = 0;
    busyErr = 0;
    for (int c = 0; c <= rdy; c++) begin
      @(posedge clock);
      #1;
      if (c == 0) begin
        DXIR = v.ir;
        operandA = v.a;
        operandB = v.b;
      end else begin
        operandA = $urandom;
        operandB = $urandom;
      end
      wbBusy = (c >= v.lat) && (c < rdy);
      @(negedge clock);
      if (multOrDivReady === 1'b1) begin
        pulses++;
        if (first < 0) first = c;
      end
      if (busy !== (c < rdy)) busyErr++;
      if (v.wb > 0 && c == v.lat)
        check({tag, " held"}, result, v.res);
    end
    check({tag, " readyCycle"}, 32'(first), 32'(rdy));
    check({tag, " pulses"}, 32'(pulses), 32'd1);
    check({tag, " busyErr"}, 32'(busyErr), 32'd0);
    check({tag, " result"}, result, v.res);
    check({tag, " exception"}, {31'd0, exception}, {31'd0, v.exc});
    check({tag, " PWIR"}, PWIR, v.ir);
  endtask

  task automatic idle(input int n, input string tag);
    int err;
    err = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      DXIR = NOP;
      operandA = $urandom;
      operandB = $urandom;
      wbBusy = 1'($urandom);
      @(negedge clock);
      if (busy !== 1'b0 || multOrDivReady !== 1'b0) err++;
    end
    check({tag, " idleErr"}, 32'(err), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    vecs[0]  = '{mk(0, 1, 6),  32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 33, 0};
    vecs[1]  = '{mk(0, 2, 6),  32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 33, 0};
    vecs[2]  = '{mk(0, 3, 6),  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 33, 0};
    vecs[3]  = '{mk(0, 4, 6),  32'hFFFF0000, 32'h00008000, 32'h80000000, 1'b0, 33, 0};
    vecs[4]  = '{mk(0, 5, 6),  32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b1, 33, 0};
    vecs[5]  = '{mk(0, 6, 6),  32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 33, 0};
    vecs[6]  = '{mk(0, 7, 7),  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 33, 0};
    vecs[7]  = '{mk(0, 8, 7),  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 33, 0};
    vecs[8]  = '{mk(0, 9, 7),  32'd5,        32'd0,        32'h00000000, 1'b1, 1,  0};
    vecs[9]  = '{mk(0, 10, 7), 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, 33, 0};
    vecs[10] = '{mk(0, 11, 7), 32'h80000000, 32'd1,        32'h80000000, 1'b0, 33, 0};
    vecs[11] = '{mk(0, 12, 7), 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 1'b0, 33, 0};
    vecs[12] = '{mk(0, 13, 7), 32'd3,        32'd7,        32'h00000000, 1'b0, 33, 0};
    vecs[13] = '{mk(0, 14, 6), 32'd1234,     32'hFFFFFFFB, 32'hFFFFE7E6, 1'b0, 33, 3};
    vecs[14] = '{mk(0, 15, 7), 32'd5,        32'd0,        32'h00000000, 1'b1, 1,  2};
    vecs[15] = '{mk(0, 16, 7), 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 1'b0, 33, 1};

    reset_n = 1'b0;
    DXIR = NOP;
    operandA = '0;
    operandB = '0;
    wbBusy = 1'b0;
    #2;
    check("rst PWIR", PWIR, 32'd0);
    check("rst result", result, 32'd0);
    check("rst exception", {31'd0, exception}, 32'd0);
    check("rst ready", {31'd0, multOrDivReady}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle(3, "post-reset");

    for (int i = 0; i < 16; i++) begin
      runOp(vecs[i], $sformatf("v%0d", i));
      idle(3, $sformatf("v%0d", i));
    end

    // mul immediately followed by div in DX
    rv = '{mk(0, 17, 6), 32'd300, 32'd300, 32'd90000, 1'b0, 33, 0};
    runOp(rv, "b2b mul");
    rv = '{mk(0, 18, 7), 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 1'b0, 33, 0};
    runOp(rv, "b2b div");
    idle(3, "b2b");

    // reset in the middle of a multiply
    @(posedge clock);
    #1;
    DXIR = mk(0, 19, 6);
    operandA = 32'd1234;
    operandB = 32'd5;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clock);
      #1;
    end
    reset_n = 1'b0;
    #1;
    check("midrst PWIR", PWIR, 32'd0);
    check("midrst result", result, 32'd0);
    check("midrst exception", {31'd0, exception}, 32'd0);
    check("midrst ready", {31'd0, multOrDivReady}, 32'd0);
    check("midrst busy", {31'd0, busy}, 32'd0);
    DXIR = NOP;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle(40, "midrst");
    check("midrst PWIR after", PWIR, 32'd0);
    check("midrst result after", result, 32'd0);

    runOp(vecs[0], "after reset");
    idle(3, "after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
